// File: rtl/ceespu_int_pkg.sv
// ceespu_int_pkg
//   Shared definitions for the ceespu interrupt controller and the decode
//   stage that consumes it.
//   - en_sel_e : which source updates the global interrupt enable this cycle,
//                listed from highest to lowest priority. Reset sits above all
//                of them and is handled directly in the register.
//   - chan_w() : width of a channel index for a given channel count (min 1).
//   - vec_of() : branch address for a channel, before truncation to PC width.
package ceespu_int_pkg;

  // Upper bound on channel count, and the index width it needs.
  localparam int MAX_CHAN   = 16;
  localparam int CHAN_W_MAX = 4;

  typedef enum logic [1:0] {
    EN_HOLD = 2'd0,  // nothing touches the enable
    EN_ACK  = 2'd1,  // interrupt taken: disable
    EN_EINT = 2'd2,  // EINT instruction: load operand bit
    EN_RETI = 2'd3   // return through c17: re-enable
  } en_sel_e;

  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [31:0] vec_of(input logic [31:0] base,
                                         input logic [31:0] stride,
                                         input logic [31:0] chan);
    return base + chan * stride;
  endfunction

endpackage

// File: rtl/ceespu_prio_enc.sv
// ceespu_prio_enc
//   Lowest-index-first priority encoder.
//   Ports:
//     req   in  N      request bits
//     valid out 1      at least one request bit set
//     idx   out IDX_W  index of the lowest set request bit (0 when none)
module ceespu_prio_enc #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  // Scan from the top down so the last hit, the lowest index, wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/ceespu_int_ctrl.sv
// ceespu_int_ctrl
//   Interrupt controller for the ceespu decode stage. N_CHAN sources, each
//   edge or level triggered, are synchronised, latched into pending bits,
//   masked and reduced by fixed priority (lowest index first) to a single
//   registered request with its channel and branch vector. The request is
//   held until decode acknowledges it. The global enable is cleared on
//   acknowledge and restored by EINT or by the return through c17.
//   Ports:
//     I_clk, I_rst        clock, synchronous active-high reset
//     I_irq               raw interrupt sources
//     I_mask_we/_wdata    mask write (1 = channel enabled)
//     I_eint_we/_val      EINT executed, operand bit
//     I_reti              return from interrupt executed
//     I_int_ack           decode took the interrupt this cycle
//     O_int               request to decode
//     O_int_vector        branch address of the request
//     O_int_chan          channel of the request
//     O_pending           pending bits
//     O_mask              current mask
//     O_int_enabled       global enable
module ceespu_int_ctrl
  import ceespu_int_pkg::*;
#(
  parameter int              N_CHAN      = 4,
  parameter int              PC_W        = 14,
  parameter int              VEC_BASE    = 0,
  parameter int              VEC_STRIDE  = 1,
  parameter logic [N_CHAN-1:0] EDGE_MASK  = {N_CHAN{1'b1}},
  parameter logic [N_CHAN-1:0] MASK_RESET = {N_CHAN{1'b1}},
  parameter int              SYNC_STAGES = 2
) (
  input  logic                        I_clk,
  input  logic                        I_rst,
  input  logic [N_CHAN-1:0]           I_irq,
  input  logic                        I_mask_we,
  input  logic [N_CHAN-1:0]           I_mask_wdata,
  input  logic                        I_eint_we,
  input  logic                        I_eint_val,
  input  logic                        I_reti,
  input  logic                        I_int_ack,
  output logic                        O_int,
  output logic [PC_W-1:0]             O_int_vector,
  output logic [chan_w(N_CHAN)-1:0]   O_int_chan,
  output logic [N_CHAN-1:0]           O_pending,
  output logic [N_CHAN-1:0]           O_mask,
  output logic                        O_int_enabled
);

  localparam int CHAN_W = chan_w(N_CHAN);

  logic [N_CHAN-1:0] irq_s;
  logic [N_CHAN-1:0] prev_p0;
  logic [N_CHAN-1:0] pend_p1;
  logic [N_CHAN-1:0] pend_d;
  logic [N_CHAN-1:0] rise;
  logic [N_CHAN-1:0] ack_clr;
  logic [N_CHAN-1:0] eligible;
  logic [N_CHAN-1:0] mask_q;
  logic              en_q;
  logic              int_p2;
  logic [CHAN_W-1:0] chan_p2;
  logic [PC_W-1:0]   vec_p2;
  logic              win_vld;
  logic [CHAN_W-1:0] win_idx;
  logic              ack_take;
  en_sel_e           en_sel;

  // ---- stage p0: synchroniser chain, output irq_s ----
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign irq_s = I_irq;
    end else begin : g_sync
      logic [N_CHAN-1:0] irq_sync_p [SYNC_STAGES];
      always_ff @(posedge I_clk) begin
        if (I_rst) begin
          for (int k = 0; k < SYNC_STAGES; k++) irq_sync_p[k] <= '0;
        end else begin
          irq_sync_p[0] <= I_irq;
          for (int k = 1; k < SYNC_STAGES; k++) irq_sync_p[k] <= irq_sync_p[k-1];
        end
      end
      assign irq_s = irq_sync_p[SYNC_STAGES-1];
    end
  endgenerate

  // An acknowledge only counts while a request is actually outstanding.
  always_comb begin
    ack_take = I_int_ack & int_p2;
    rise     = irq_s & ~prev_p0;
    eligible = pend_p1 & mask_q;
    ack_clr  = '0;
    pend_d   = '0;
    for (int i = 0; i < N_CHAN; i++) begin
      ack_clr[i] = ack_take && EDGE_MASK[i] && (chan_p2 == CHAN_W'(i));
      // Edge: sticky, and a fresh edge beats a same-cycle clear.
      // Level: pending simply follows the synchronised source.
      pend_d[i]  = EDGE_MASK[i] ? ((pend_p1[i] & ~ack_clr[i]) | rise[i])
                                : irq_s[i];
    end
  end

  // ---- stage p1: edge history and pending bits ----
  // prev resets to 0 so a source already high at reset release is an edge.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      prev_p0 <= '0;
      pend_p1 <= '0;
    end else begin
      prev_p0 <= irq_s;
      pend_p1 <= pend_d;
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst)          mask_q <= MASK_RESET;
    else if (I_mask_we) mask_q <= I_mask_wdata;
  end

  ceespu_prio_enc #(
    .N     (N_CHAN),
    .IDX_W (CHAN_W)
  ) u_prio (
    .req   (eligible),
    .valid (win_vld),
    .idx   (win_idx)
  );

  // ---- stage p2: request register, frozen until acknowledged ----
  // A new request is not raised in a cycle that carries an ack, so a late
  // ack of the previous request can never be mistaken for this one.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      int_p2  <= 1'b0;
      chan_p2 <= '0;
      vec_p2  <= '0;
    end else if (int_p2) begin
      if (ack_take) int_p2 <= 1'b0;
    end else if (en_q && win_vld && !I_int_ack) begin
      int_p2  <= 1'b1;
      chan_p2 <= win_idx;
      vec_p2  <= PC_W'(vec_of(VEC_BASE, VEC_STRIDE, 32'(win_idx)));
    end
  end

  always_comb begin
    en_sel = EN_HOLD;
    if (ack_take)       en_sel = EN_ACK;
    else if (I_eint_we) en_sel = EN_EINT;
    else if (I_reti)    en_sel = EN_RETI;
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      en_q <= 1'b1;
    end else begin
      case (en_sel)
        EN_ACK:  en_q <= 1'b0;
        EN_EINT: en_q <= I_eint_val;
        EN_RETI: en_q <= 1'b1;
        default: en_q <= en_q;
      endcase
    end
  end

  assign O_int         = int_p2;
  assign O_int_vector  = vec_p2;
  assign O_int_chan    = chan_p2;
  assign O_pending     = pend_p1;
  assign O_mask        = mask_q;
  assign O_int_enabled = en_q;

endmodule

// File: tb/tb_ceespu_int_ctrl.sv
// Testbench for ceespu_int_ctrl: 4 channels, ch0 level, ch1..3 edge,
// two synchroniser stages, vector stride 4.
module tb_ceespu_int_ctrl;

  localparam int         NC   = 4;
  localparam int         PCW  = 14;
  localparam int         VB   = 0;
  localparam int         VS   = 4;
  localparam int         S    = 2;
  localparam logic [3:0] EDGE = 4'b1110;
  localparam logic [3:0] MRST = 4'b1111;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [3:0]      irq = '0;
  logic            mask_we = 1'b0;
  logic [3:0]      mask_wdata = '0;
  logic            eint_we = 1'b0;
  logic            eint_val = 1'b0;
  logic            reti = 1'b0;
  logic            ack = 1'b0;
  logic            o_int;
  logic [PCW-1:0]  o_vec;
  logic [1:0]      o_chan;
  logic [3:0]      o_pend;
  logic [3:0]      o_mask;
  logic            o_en;

  int checks = 0;
  int failures = 0;

  ceespu_int_ctrl #(
    .N_CHAN      (NC),
    .PC_W        (PCW),
    .VEC_BASE    (VB),
    .VEC_STRIDE  (VS),
    .EDGE_MASK   (EDGE),
    .MASK_RESET  (MRST),
    .SYNC_STAGES (S)
  ) dut (
    .I_clk         (clk),
    .I_rst         (rst),
    .I_irq         (irq),
    .I_mask_we     (mask_we),
    .I_mask_wdata  (mask_wdata),
    .I_eint_we     (eint_we),
    .I_eint_val    (eint_val),
    .I_reti        (reti),
    .I_int_ack     (ack),
    .O_int         (o_int),
    .O_int_vector  (o_vec),
    .O_int_chan    (o_chan),
    .O_pending     (o_pend),
    .O_mask        (o_mask),
    .O_int_enabled (o_en)
  );

  always #5 clk = ~clk;

  // Reference model: the source seen by the controller is the raw input
  // from S cycles ago, kept in a queue.
  bit [3:0] m_hist[$];
  bit [3:0] m_prev, m_pend, m_mask;
  bit       m_en, m_req;
  int       m_chan, m_vec;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic model_clock();
    bit [3:0] seen, np, elig;
    bit       taken;
    int       win;
    if (rst) begin
      m_hist.delete();
      for (int k = 0; k < S; k++) m_hist.push_back(4'b0);
      m_prev = '0; m_pend = '0; m_mask = MRST;
      m_en = 1'b1; m_req = 1'b0; m_chan = 0; m_vec = 0;
    end else begin
      seen  = m_hist[0];
      taken = ack && m_req;
      for (int c = 0; c < NC; c++) begin
        if (EDGE[c]) np[c] = (m_pend[c] && !(taken && m_chan == c)) || (seen[c] && !m_prev[c]);
        else         np[c] = seen[c];
      end
      elig = m_pend & m_mask;
      win = -1;
      for (int c = NC - 1; c >= 0; c--) if (elig[c]) win = c;
      if (m_req) begin
        if (taken) m_req = 1'b0;
      end else if (m_en && win >= 0 && !ack) begin
        m_req = 1'b1; m_chan = win; m_vec = (VB + win * VS) % (1 << PCW);
      end
      if (taken)        m_en = 1'b0;
      else if (eint_we) m_en = eint_val;
      else if (reti)    m_en = 1'b1;
      if (mask_we) m_mask = mask_wdata;
      m_pend = np;
      m_prev = seen;
      void'(m_hist.pop_front());
      m_hist.push_back(irq);
    end
  endtask

  // One clock: model follows the inputs present at the edge, outputs are
  // compared 1 time unit later, then one-shot inputs are released.
  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
    chk("model_int",  o_int,  m_req);
    chk("model_vec",  o_vec,  m_vec);
    chk("model_chan", o_chan, m_chan);
    chk("model_pend", o_pend, m_pend);
    chk("model_mask", o_mask, m_mask);
    chk("model_en",   o_en,   m_en);
    rst = 0; mask_we = 0; eint_we = 0; eint_val = 0; reti = 0; ack = 0;
  endtask

  task automatic wait_int(input string nm, input int budget);
    int n = 0;
    while (o_int !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    chk(nm, o_int, 1);
  endtask

  typedef struct {
    logic [3:0]  irq;
    logic        ack;
    logic        reti;
    logic        e_int;
    logic [13:0] e_vec;
    logic [1:0]  e_chan;
    logic [3:0]  e_pend;
    logic        e_en;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // single edge on ch2: pending at cycle 3, request at cycle 4, then ack/reti
    tbl[0] = '{4'b0100, 0, 0, 0, 14'd0, 2'd0, 4'b0000, 1};
    tbl[1] = '{4'b0100, 0, 0, 0, 14'd0, 2'd0, 4'b0000, 1};
    tbl[2] = '{4'b0100, 0, 0, 0, 14'd0, 2'd0, 4'b0100, 1};
    tbl[3] = '{4'b0000, 0, 0, 1, 14'd8, 2'd2, 4'b0100, 1};
    tbl[4] = '{4'b0000, 1, 0, 0, 14'd8, 2'd2, 4'b0000, 0};
    tbl[5] = '{4'b0000, 0, 0, 0, 14'd8, 2'd2, 4'b0000, 0};
    tbl[6] = '{4'b0000, 0, 1, 0, 14'd8, 2'd2, 4'b0000, 1};

    rst = 1; step();
    rst = 1; step();
    chk("rst_int", o_int, 0);
    chk("rst_vec", o_vec, 0);
    chk("rst_chan", o_chan, 0);
    chk("rst_pend", o_pend, 0);
    chk("rst_mask", o_mask, MRST);
    chk("rst_en", o_en, 1);

    for (int r = 0; r < 7; r++) begin
      irq = tbl[r].irq; ack = tbl[r].ack; reti = tbl[r].reti;
      step();
      chk($sformatf("tbl%0d_int", r),  o_int,  tbl[r].e_int);
      chk($sformatf("tbl%0d_vec", r),  o_vec,  tbl[r].e_vec);
      chk($sformatf("tbl%0d_chan", r), o_chan, tbl[r].e_chan);
      chk($sformatf("tbl%0d_pend", r), o_pend, tbl[r].e_pend);
      chk($sformatf("tbl%0d_en", r),   o_en,   tbl[r].e_en);
    end

    // simultaneous edges on ch1 and ch3: ch1 first, then ch3
    irq = 4'b1010; step(); irq = 4'b0000;
    wait_int("dual_first_req", 10);
    chk("dual_first_chan", o_chan, 1);
    chk("dual_first_vec", o_vec, 4);
    ack = 1; step();
    chk("dual_ack_pend", o_pend, 4'b1000);
    chk("dual_ack_en", o_en, 0);
    reti = 1; step();
    wait_int("dual_second_req", 10);
    chk("dual_second_vec", o_vec, 12);
    ack = 1; step();
    reti = 1; step();
    chk("dual_end_pend", o_pend, 0);
    chk("dual_end_int", o_int, 0);

    // level ch0 held across ack: second request two cycles after reti
    irq = 4'b0001;
    wait_int("lvl_req", 10);
    chk("lvl_chan", o_chan, 0);
    ack = 1; step();
    chk("lvl_ack_int", o_int, 0);
    chk("lvl_ack_pend", o_pend[0], 1);
    step(); step();
    chk("lvl_hold_int", o_int, 0);
    reti = 1; step();
    chk("lvl_reti_int", o_int, 0);
    chk("lvl_reti_en", o_en, 1);
    step();
    chk("lvl_rearm_int", o_int, 1);
    chk("lvl_rearm_chan", o_chan, 0);
    ack = 1; irq = 4'b0000; step();
    step(); step(); step();
    reti = 1; step();
    for (int k = 0; k < 5; k++) step();
    chk("lvl_dropped_int", o_int, 0);

    // masked ch2 edge stays pending, unmask raises request two cycles later
    mask_we = 1; mask_wdata = 4'b1011; step();
    irq = 4'b0100; step(); irq = 4'b0000;
    for (int k = 0; k < 5; k++) step();
    chk("mask_int", o_int, 0);
    chk("mask_pend", o_pend[2], 1);
    mask_we = 1; mask_wdata = 4'b1111; step();
    chk("unmask_int_early", o_int, 0);
    chk("unmask_mask", o_mask, 4'b1111);
    step();
    chk("unmask_int", o_int, 1);
    chk("unmask_vec", o_vec, 8);
    ack = 1; step();
    reti = 1; step();

    // enable priority: ack beats eint and reti; eint beats reti
    irq = 4'b1000; step(); irq = 4'b0000;
    wait_int("prio_req", 10);
    ack = 1; eint_we = 1; eint_val = 1; reti = 1; step();
    chk("prio_ack_en", o_en, 0);
    eint_we = 1; eint_val = 0; reti = 1; step();
    chk("prio_eint_en", o_en, 0);
    reti = 1; step();
    chk("prio_reti_en", o_en, 1);

    // edge on ch1 arriving in the cycle ch1 is acknowledged
    irq = 4'b0010; step(); irq = 4'b0000;
    wait_int("setwin_req", 10);
    chk("setwin_chan", o_chan, 1);
    step(); step(); step();
    irq = 4'b0010; step();
    step();
    ack = 1; step();
    irq = 4'b0000;
    chk("setwin_pend", o_pend[1], 1);
    chk("setwin_int", o_int, 0);

    // reset in the middle of a request
    mask_we = 1; mask_wdata = 4'b0110; step();
    reti = 1; step();
    wait_int("rstmid_req", 10);
    chk("rstmid_chan", o_chan, 1);
    rst = 1; step();
    chk("rstmid_int", o_int, 0);
    chk("rstmid_vec", o_vec, 0);
    chk("rstmid_chan0", o_chan, 0);
    chk("rstmid_pend", o_pend, 0);
    chk("rstmid_mask", o_mask, MRST);
    chk("rstmid_en", o_en, 1);

    // randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      irq = 4'($urandom);
      if ($urandom_range(7) == 0) begin mask_we = 1; mask_wdata = 4'($urandom); end
      if ($urandom_range(9) == 0) begin eint_we = 1; eint_val = 1'($urandom); end
      if ($urandom_range(5) == 0) reti = 1;
      if (o_int) ack = ($urandom_range(2) == 0);
      else       ack = ($urandom_range(19) == 0);
      if ($urandom_range(149) == 0) rst = 1;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ceespu_int_ctrl.md
Name: ceespu_int_ctrl

Overview:
Parametrised interrupt controller that replaces the single-line, fixed 2-bit-vector interrupt handling inside the decode stage. Accepts N_CHAN interrupt sources, each configurable as edge or level. Provides synchronisation, sticky pending bits, a per-channel mask and fixed priority. Presents one registered request plus a PC-width vector to decode, held under a req/ack handshake, and tracks the global enable (EINT instruction, ack, return-through-c17).

Parameters:
N_CHAN, 4, number of interrupt sources (1..16)
PC_W, 14, width of vector/branch address
VEC_BASE, 0, vector of channel 0
VEC_STRIDE, 1, vector spacing per channel index
EDGE_MASK, {N_CHAN{1'b1}}, bit i=1: channel i edge-triggered, 0: level
MASK_RESET, {N_CHAN{1'b1}}, mask value after reset (1 = enabled)
SYNC_STAGES, 2, synchroniser flops per source (0..3; 0 = inputs already synchronous)

Ports:
I_clk  in  1  clock
I_rst  in  1  synchronous, active-high reset
I_irq  in  N_CHAN  raw interrupt sources
I_mask_we  in  1  write mask
I_mask_wdata  in  N_CHAN  new mask value
I_eint_we  in  1  EINT executed in decode
I_eint_val  in  1  EINT operand bit (instruction[0])
I_reti  in  1  branch through c17 executed (return from interrupt)
I_int_ack  in  1  decode took the interrupt this cycle
O_int  out  1  interrupt request to decode
O_int_vector  out  PC_W  branch address for the request
O_int_chan  out  $clog2(N_CHAN) (min 1)  channel being requested
O_pending  out  N_CHAN  pending bits (status)
O_mask  out  N_CHAN  current mask
O_int_enabled  out  1  global enable

Behaviour:
- Reset: sync flops=0, previous-sample=0, pending=0, mask=MASK_RESET, enable=1, O_int=0, O_int_vector=0, O_int_chan=0. Reset wins over every other input.
- Sync: s_irq = I_irq delayed by SYNC_STAGES flops.
- Edge channel: rising edge of s_irq (s_irq & ~prev) sets pending[i].
  - Pending stays set until acked.
  - An edge in the same cycle as an ack of that channel leaves pending set (set wins).
  - A source already high when reset is released counts as an edge.
- Level channel: pending[i] = s_irq[i] (registered, 1 cycle). Ack does not clear it.
- Eligible = pending & mask. Winner = lowest index among eligible bits.
- Request, registered: if !O_int && enable && |eligible && !I_int_ack:
  - O_int <= 1
  - O_int_chan <= winner
  - O_int_vector <= VEC_BASE + winner*VEC_STRIDE, truncated to PC_W
- Hold: while O_int=1, chan/vector/O_int are frozen. No withdrawal even if the source drops, the mask clears or EINT 0 occurs; the request is only retired by ack.
- Ack (I_int_ack & O_int):
  - O_int <= 0 next cycle.
  - pending[chan] cleared if that channel is edge-triggered.
  - enable <= 0.
- Ack while O_int=0: ignored.
- Enable update priority: reset > ack > I_eint_we (enable <= I_eint_val) > I_reti (enable <= 1).
- Mask write takes effect next cycle and does not affect pending bits.
- Latency, SYNC_STAGES=S, enable=1, mask set, edge at cycle 0: pending at cycle S+1, O_int at cycle S+2.
- Re-arm: after ack, a new request cannot assert before enable returns to 1 (two cycles minimum after the reti/eint cycle).

Decomposition:
- Package ceespu_int_pkg:
  - function vec_of(chan) computing VEC_BASE + chan*VEC_STRIDE
  - localparam CHAN_W = max(1, $clog2(N_CHAN))
  - enable-priority encoding constants
- Sub-module ceespu_prio_enc: parametrised lowest-index-first priority encoder (N inputs → valid + index), reused by decode later.

Test Plan:
- Reset then single edge on ch2 (N_CHAN=4, S=2, VEC_STRIDE=4): O_int=1 at cycle 4, O_int_vector=8, O_int_chan=2. Ack → O_int=0, pending[2]=0, O_int_enabled=0.
- Simultaneous edges on ch1 and ch3: ch1 served first (vector 4). After I_reti and ack flow, ch3 served (vector 12). pending=0 at end.
- Level ch0 (EDGE_MASK=4'b1110) held high across an ack then I_reti: second request issued at reti+2 cycles. Source lowered before reti → no second request.
- Mask ch2=0 then edge on ch2: no O_int, pending[2]=1. Mask write 4'b1111 → O_int two cycles later with vector for ch2.
- Same cycle: I_int_ack, I_eint_we=1/I_eint_val=1, I_reti=1 → O_int_enabled=0 (ack wins). Next cycle I_eint_we with val 0 and I_reti → enable stays 0.
- Edge on ch1 in the ack cycle of ch1 → pending[1] stays 1. Reset asserted mid-request → all outputs at reset values next cycle, mask=MASK_RESET.
